sop_truth_table_checker: RTL and testbench

- Sequential driver/checker that sits around the 3-input SOP gate `dataflow_gate_3` (F = B'(A'+C'), minterms 0,1,4).
- Upstream role: steps the gate's A/B/C inputs through all 8 combinations on a start request.
- Downstream role: samples F after a settle delay, builds the 8-bit minterm mask, and compares it against an expected mask.
- Reports pass/fail and a mismatch count, giving the gate family a self-checking hardware harness.

---
 rtl/sop_tt_check_pkg.sv | 19 +
 rtl/sop_tt_vec_sequencer.sv | 55 +++++
 rtl/sop_truth_table_checker.sv | 139 +++++++++++++
 tb/tb_sop_truth_table_checker.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sop_tt_check_pkg.sv
// Shared types and constants for the SOP truth-table checker.
// The checker drives all 8 {A,B,C} vectors into the gate and compares F against a reference mask.
package sop_tt_check_pkg;

   localparam int unsigned VEC_COUNT = 8;
   localparam int unsigned IDX_W     = 3;
   localparam int unsigned SETTLE_W  = 4;

   // Minterms 0,1,4 of F = B'(A'+C')
   localparam logic [VEC_COUNT-1:0] EXPECTED_DEFAULT = 8'h13;

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      SAMPLE,
      DONE
   } state_e;

endpackage

// File: rtl/sop_tt_vec_sequencer.sv
// Vector sequencer: owns the {A,B,C} index and the settle counter.
// It raises settled_o on the final DRIVE cycle of each vector.
module sop_tt_vec_sequencer
   import sop_tt_check_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             drive_i,
   input  logic             sample_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             settled_o,
   output logic             last_o
);

   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
   localparam logic [IDX_W-1:0]    IDX_LAST    = IDX_W'(VEC_COUNT - 1);

   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [SETTLE_W-1:0] cnt_q, cnt_d;

   // The index stops at the last vector so the gate inputs stay at 3'b111 after a sweep.
   always_comb begin
      idx_d = idx_q;
      cnt_d = cnt_q;
      if (clear_i) begin
         idx_d = '0;
         cnt_d = '0;
      end else if (drive_i) begin
         cnt_d = cnt_q + SETTLE_W'(1);
      end else if (sample_i) begin
         cnt_d = '0;
         if (idx_q != IDX_LAST) begin
            idx_d = idx_q + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         idx_q <= '0;
         cnt_q <= '0;
      end else begin
         idx_q <= idx_d;
         cnt_q <= cnt_d;
      end
   end

   assign idx_o     = idx_q;
   assign settled_o = drive_i && (cnt_q == SETTLE_LAST);
   assign last_o    = (idx_q == IDX_LAST);

endmodule

// File: rtl/sop_truth_table_checker.sv
// Self-checking harness for the 3-input SOP gate: sweeps A/B/C, captures F, compares against EXPECTED.
// Optional SOP_TT_CHECK_FIRST_FAIL_EN adds first_fail_idx/first_fail_vld outputs.
module sop_truth_table_checker
   import sop_tt_check_pkg::*;
#(
   parameter int unsigned          SETTLE_CYCLES = 1,
   parameter logic [VEC_COUNT-1:0] EXPECTED      = EXPECTED_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       f_in,
   output logic       a_out,
   output logic       b_out,
   output logic       c_out,
   output logic       busy,
   output logic       done,
   output logic [7:0] mask,
   output logic       pass,
   output logic [3:0] mismatch_cnt
`ifdef SOP_TT_CHECK_FIRST_FAIL_EN
   ,
   output logic [2:0] first_fail_idx,
   output logic [0:0] first_fail_vld
`endif
);

   state_e           state_q;
   logic             busy_q;
   logic             done_q;
   logic             pass_q;
   logic [7:0]       mask_q;
   logic [3:0]       mm_q;

   logic             accept;
   logic             in_drive;
   logic             in_sample;
   logic             settled;
   logic             last;
   logic             miss;
   logic [IDX_W-1:0] idx;

   assign accept    = (state_q == IDLE) && start;
   assign in_drive  = (state_q == DRIVE);
   assign in_sample = (state_q == SAMPLE);
   assign miss      = in_sample && (f_in != EXPECTED[idx]);

   sop_tt_vec_sequencer #(
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) u_seq (
      .clk_i    (clk),
      .rst_i    (rst),
      .clear_i  (accept),
      .drive_i  (in_drive),
      .sample_i (in_sample),
      .idx_o    (idx),
      .settled_o(settled),
      .last_o   (last)
   );

   // pass is resolved in DONE so it sees the count including the final sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         mask_q  <= '0;
         mm_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= DRIVE;
                  busy_q  <= 1'b1;
                  pass_q  <= 1'b0;
                  mask_q  <= '0;
                  mm_q    <= '0;
               end
            end
            DRIVE: begin
               if (settled) begin
                  state_q <= SAMPLE;
               end
            end
            SAMPLE: begin
               mask_q[idx] <= f_in;
               if (miss) begin
                  mm_q <= mm_q + 4'd1;
               end
               if (last) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= DRIVE;
               end
            end
            DONE: begin
               pass_q  <= (mm_q == '0);
               done_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign a_out        = idx[2];
   assign b_out        = idx[1];
   assign c_out        = idx[0];
   assign busy         = busy_q;
   assign done         = done_q;
   assign mask         = mask_q;
   assign pass         = pass_q;
   assign mismatch_cnt = mm_q;

`ifdef SOP_TT_CHECK_FIRST_FAIL_EN
   logic [IDX_W-1:0] ff_idx_q;
   logic             ff_vld_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ff_idx_q <= '0;
         ff_vld_q <= 1'b0;
      end else if (accept) begin
         ff_idx_q <= '0;
         ff_vld_q <= 1'b0;
      end else if (miss && !ff_vld_q) begin
         ff_idx_q <= idx;
         ff_vld_q <= 1'b1;
      end
   end

   assign first_fail_idx = ff_idx_q;
   assign first_fail_vld = ff_vld_q;
`endif

endmodule

// File: tb/tb_sop_truth_table_checker.sv
// Bench for sop_truth_table_checker: two instances (SETTLE_CYCLES 1 and 3) against a sweep-level model.
// Honours SOP_TT_CHECK_FIRST_FAIL_EN when defined.
module tb_sop_truth_table_checker;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   int   gate_mode = 0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   logic       f0, a0, b0, c0, busy0, done0, pass0;
   logic [7:0] mask0;
   logic [3:0] mm0;
   logic       f1, a1, b1, c1, busy1, done1, pass1;
   logic [7:0] mask1;
   logic [3:0] mm1;
`ifdef SOP_TT_CHECK_FIRST_FAIL_EN
   logic [2:0] ffi0, ffi1;
   logic [0:0] ffv0, ffv1;
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference gate: correct F = B'(A'+C'), faulty F = B'
   function automatic logic gate_f(input int mode, input logic [2:0] v);
      logic a, b, c;
      a = v[2];
      b = v[1];
      c = v[0];
      if (mode == 0) return ~b & (~a | ~c);
      return ~b;
   endfunction

   function automatic logic [7:0] tt_of(input int mode);
      logic [7:0] r;
      logic [2:0] bits;
      r = '0;
      for (int v = 0; v < 8; v++) begin
         bits = 3'(v);
         r[v] = gate_f(mode, bits);
      end
      return r;
   endfunction

   always_comb f0 = gate_f(gate_mode, {a0, b0, c0});
   always_comb f1 = gate_f(gate_mode, {a1, b1, c1});

   sop_truth_table_checker dut0 (
      .clk(clk), .rst(rst), .start(start), .f_in(f0),
      .a_out(a0), .b_out(b0), .c_out(c0), .busy(busy0), .done(done0),
      .mask(mask0), .pass(pass0), .mismatch_cnt(mm0)
`ifdef SOP_TT_CHECK_FIRST_FAIL_EN
      , .first_fail_idx(ffi0), .first_fail_vld(ffv0)
`endif
   );

   sop_truth_table_checker #(.SETTLE_CYCLES(3), .EXPECTED(8'h13)) dut1 (
      .clk(clk), .rst(rst), .start(start), .f_in(f1),
      .a_out(a1), .b_out(b1), .c_out(c1), .busy(busy1), .done(done1),
      .mask(mask1), .pass(pass1), .mismatch_cnt(mm1)
`ifdef SOP_TT_CHECK_FIRST_FAIL_EN
      , .first_fail_idx(ffi1), .first_fail_vld(ffv1)
`endif
   );

   task automatic cmp(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s inst%0d cyc %0d: got %0h expected %0h", nm, inst, cyc, act, exp);
      end
   endtask

   // Model: m_t is edges since the accepted start (-1 = never started / reset).
   int         m_t[2] = '{-1, -1};
   logic [7:0] m_tt[2] = '{8'h00, 8'h00};

   function automatic int period(input int i);
      return (i == 0) ? 2 : 4;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) m_t[i] <= -1;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if ((m_t[i] < 0 || m_t[i] >= 8 * period(i) + 1) && start) begin
               m_t[i]  <= 0;
               m_tt[i] <= tt_of(gate_mode);
            end else if (m_t[i] >= 0 && m_t[i] <= 8 * period(i)) begin
               m_t[i] <= m_t[i] + 1;
            end else if (m_t[i] == 8 * period(i) + 1) begin
               m_t[i] <= 8 * period(i) + 2;
            end
         end
      end
   end

   task automatic check_inst(input int i, input logic [2:0] abc, input logic bsy, input logic dn,
                             input logic [7:0] msk, input logic ps, input logic [3:0] mm
`ifdef SOP_TT_CHECK_FIRST_FAIL_EN
                             , input logic [2:0] ffi, input logic ffv
`endif
                            );
      int t, p, l, n, e_idx, e_mm;
      logic e_busy, e_done, e_pass, e_ffv;
      logic [7:0] low, diff;
      logic [2:0] e_ffi;
      t = m_t[i];
      p = period(i);
      l = 8 * p;
      if (t < 0) begin
         n = 0; e_idx = 0; e_busy = 1'b0; e_done = 1'b0;
      end else begin
         n      = (t / p > 8) ? 8 : t / p;
         e_idx  = (t < l) ? t / p : 7;
         e_busy = (t < l);
         e_done = (t == l + 1);
      end
      low  = (n >= 8) ? 8'hFF : 8'((1 << n) - 1);
      diff = (m_tt[i] ^ 8'h13) & low;
      e_mm = $countones(diff);
      e_pass = (t >= l + 1) && (e_mm == 0);
      e_ffv = (diff != 8'h00);
      e_ffi = '0;
      for (int b = 7; b >= 0; b--) if (diff[b]) e_ffi = 3'(b);
      cmp("abc", i, 32'(abc), 32'(e_idx));
      cmp("busy", i, 32'(bsy), 32'(e_busy));
      cmp("done", i, 32'(dn), 32'(e_done));
      cmp("mask", i, 32'(msk), 32'(m_tt[i] & low));
      cmp("mismatch_cnt", i, 32'(mm), 32'(e_mm));
      cmp("pass", i, 32'(ps), 32'(e_pass));
`ifdef SOP_TT_CHECK_FIRST_FAIL_EN
      cmp("ff_vld", i, 32'(ffv), 32'(e_ffv));
      if (e_ffv) cmp("ff_idx", i, 32'(ffi), 32'(e_ffi));
`endif
   endtask

   int done_n[2];
   int done_cyc[2];
   int hold1[8];

   always @(negedge clk) begin
`ifdef SOP_TT_CHECK_FIRST_FAIL_EN
      check_inst(0, {a0, b0, c0}, busy0, done0, mask0, pass0, mm0, ffi0, ffv0[0]);
      check_inst(1, {a1, b1, c1}, busy1, done1, mask1, pass1, mm1, ffi1, ffv1[0]);
`else
      check_inst(0, {a0, b0, c0}, busy0, done0, mask0, pass0, mm0);
      check_inst(1, {a1, b1, c1}, busy1, done1, mask1, pass1, mm1);
`endif
      if (done0) begin done_n[0]++; done_cyc[0] = cyc; end
      if (done1) begin done_n[1]++; done_cyc[1] = cyc; end
      if (busy1) hold1[{a1, b1, c1}]++;
   end

   task automatic clear_mon();
      done_n[0] = 0; done_n[1] = 0;
      done_cyc[0] = 0; done_cyc[1] = 0;
      for (int v = 0; v < 8; v++) hold1[v] = 0;
   endtask

   task automatic do_start(output int k);
      @(posedge clk); #2 start = 1'b1;
      @(posedge clk); #1 k = cyc; #1 start = 1'b0;
   endtask

   initial begin
      int k;
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      cmp("reset_mask", 0, 32'(mask0), 32'h0);
      cmp("reset_busy", 0, 32'(busy0), 32'h0);

      // Correct gate, both settle settings
      clear_mon();
      do_start(k);
      repeat (40) @(posedge clk);
      cmp("lat_s1", 0, 32'(done_cyc[0] - k), 32'd17);
      cmp("lat_s3", 1, 32'(done_cyc[1] - k), 32'd33);
      cmp("good_mask", 0, 32'(mask0), 32'h13);
      cmp("good_pass", 0, 32'(pass0), 32'h1);
      cmp("good_mm", 0, 32'(mm0), 32'h0);
      cmp("hold_010", 1, 32'(hold1[2]), 32'd4);
      cmp("hold_111", 1, 32'(hold1[7]), 32'd4);
      cmp("abc_after", 0, 32'({a0, b0, c0}), 32'h7);

      // Faulty gate F = B'
      gate_mode = 1;
      clear_mon();
      do_start(k);
      repeat (40) @(posedge clk);
      cmp("bad_mask", 0, 32'(mask0), 32'h33);
      cmp("bad_pass", 0, 32'(pass0), 32'h0);
      cmp("bad_mm", 0, 32'(mm0), 32'h1);
`ifdef SOP_TT_CHECK_FIRST_FAIL_EN
      cmp("bad_ffi", 0, 32'(ffi0), 32'h5);
      cmp("bad_ffv", 0, 32'(ffv0), 32'h1);
`endif
      gate_mode = 0;

      // start re-pulsed at cycles 5 and 10 of the sweep
      clear_mon();
      do_start(k);
      repeat (4) @(posedge clk); #2 start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
      repeat (4) @(posedge clk); #2 start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
      repeat (40) @(posedge clk);
      cmp("repulse_dones", 0, 32'(done_n[0]), 32'd1);
      cmp("repulse_lat", 0, 32'(done_cyc[0] - k), 32'd17);
      cmp("repulse_mask", 0, 32'(mask0), 32'h13);

      // Asynchronous reset mid-sweep
      clear_mon();
      do_start(k);
      repeat (8) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      cmp("arst_busy", 0, 32'(busy0), 32'h0);
      cmp("arst_mask", 0, 32'(mask0), 32'h0);
      cmp("arst_abc", 0, 32'({a0, b0, c0}), 32'h0);
      @(posedge clk); #2 rst = 1'b0;
      clear_mon();
      do_start(k);
      repeat (40) @(posedge clk);
      cmp("arst_resweep_mask", 0, 32'(mask0), 32'h13);
      cmp("arst_resweep_mask", 1, 32'(mask1), 32'h13);

      // start held high: back-to-back sweeps
      clear_mon();
      @(posedge clk); #2 start = 1'b1;
      @(posedge clk); #1 k = cyc;
      repeat (18) @(posedge clk);
      @(negedge clk);
      cmp("b2b_mask_clr", 0, 32'(mask0), 32'h0);
      cmp("b2b_busy", 0, 32'(busy0), 32'h1);
      repeat (18) @(posedge clk);
      #2 start = 1'b0;
      cmp("b2b_dones", 0, 32'(done_n[0]), 32'd2);
      cmp("b2b_lat2", 0, 32'(done_cyc[0] - k), 32'd35);
      repeat (80) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

endmodule
